sumsq_acc_fsm: RTL and testbench
================================

SUMSQ_ACC_FSM -- requirements
Module: sumsq_acc_fsm

Interface
REQ-001 SHALL have parameter-free ports only; no parameters.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 x  input  32  IEEE-754 single-precision square from the pow2 stage (bit 31 sign, 30-23 exponent, 22-0 mantissa).
REQ-005 err_i  input  1  overflow flag from the pow2 stage, qualified by r_i.
REQ-006 r_i  input  1  input-valid strobe; sampled only in IDLE.
REQ-007 clr  input  1  accumulator clear; sampled only in IDLE.
REQ-008 res  output  32  accumulated sum, IEEE-754 single.
REQ-009 err  output  1  sticky error flag.
REQ-010 r_o  output  1  one-cycle result-valid pulse.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE -> ALIGN -> ADD -> NORM -> PACK -> IDLE, advancing one state per clock after leaving IDLE.
REQ-013 In IDLE with r_i=1, SHALL capture x and err_i and go to ALIGN; with r_i=0, SHALL stay in IDLE.
REQ-014 SHALL ignore r_i and clr in every state other than IDLE; no input queuing.
REQ-015 clr=1 in IDLE SHALL zero the accumulator and err at that edge; with clr=1 and r_i=1 on the same edge, the result SHALL equal x alone (clear first, then accumulate).
REQ-016 SHALL treat x[31] as 0 (operands are non-negative squares); an exponent of 0 SHALL be treated as the value zero (no denormals).
REQ-017 ALIGN: SHALL select the operand with the larger exponent, form 24-bit mantissas with a hidden 1, and right-shift the smaller one by the exponent difference; a difference of 25 or more SHALL make the smaller contribution 0.
REQ-018 ADD: SHALL form a 25-bit unsigned mantissa sum.
REQ-019 NORM: on sum bit 24 = 1, SHALL shift right 1 and increment the exponent; rounding SHALL be truncation.
REQ-020 If either operand is zero, the sum SHALL equal the other operand bit-exactly.
REQ-021 If the result exponent reaches 255, SHALL saturate the accumulator to 0x7F800000 and set err; later additions SHALL keep 0x7F800000.
REQ-022 err SHALL be sticky: set by captured err_i=1 or by overflow, cleared only by clr or reset.
REQ-023 PACK: SHALL write the accumulator to res, set r_o=1 for exactly one cycle, and return to IDLE.
REQ-024 Latency: for r_i captured at edge N, res/err SHALL update and r_o SHALL go high at edge N+4 and fall at edge N+5; the next r_i SHALL be accepted at edge N+5.
REQ-025 res SHALL hold its value between PACK states; clr SHALL NOT change res until the next PACK.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, accumulator=0, res=0x00000000, err=0, r_o=0, busy=0, independent of clk.
REQ-027 Reset mid-operation SHALL abort the addition without a r_o pulse; the first r_i after release SHALL accumulate onto zero.

Verification
REQ-028 Reset, then r_i with x=0x3F800000 twice -> r_o pulses 4 edges after each capture; res=0x3F800000, then 0x40000000; err=0.
REQ-029 clr, then x=0x40800000 followed by x=0x3F800000 -> res=0x40A00000 (5.0).
REQ-030 clr, then x=0x4E800000 followed by x=0x3F800000 (exponent diff 30) -> res=0x4E800000.
REQ-031 clr, then x=0x7F000000 twice -> res=0x7F800000, err=1; a following x=0x3F800000 leaves res=0x7F800000, err=1.
REQ-032 clr=1 and r_i=1 on the same edge with x=0x41100000 after a nonzero sum -> res=0x41100000, err=0; err_i=1 on a capture -> err=1.
REQ-033 rst_n pulsed low during ADD -> no r_o, res=0, busy=0; next x=0x40400000 -> res=0x40400000.

Source files
------------

// File: rtl/sumsq_acc_fsm.sv
// Sum-of-squares accumulator: adds non-negative IEEE-754 single operands into a
// running sum through a five-state sequence (IDLE, ALIGN, ADD, NORM, PACK).
// Rounding is truncation. Denormals are treated as zero. Overflow saturates to +inf.
module sumsq_acc_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  input  logic        err_i,
  input  logic        r_i,
  input  logic        clr,
  output logic [31:0] res,
  output logic        err,
  output logic        r_o,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StPack} state_e;

  localparam logic [31:0] PosInf = 32'h7F80_0000;

  state_e      state_q, state_d;
  logic [31:0] acc_q;
  logic [30:0] op_q;          // sign is dropped on capture; squares are never negative
  logic        eflag_q;
  logic [7:0]  exp_q;
  logic [23:0] man_a_q, man_b_q;
  logic [24:0] sum_q;
  logic        bypass_q;
  logic [31:0] bypass_val_q;
  logic [31:0] sum_word_q;
  logic        ovf_q;
  logic [31:0] res_q;
  logic        err_q;
  logic        r_o_q;

  // Align-stage operands
  logic [7:0]  ea, eb, big_e, diff;
  logic        a_big, a_zero, b_zero;
  logic [23:0] big_m, small_m, small_sh;
  logic [31:0] bypass_val;

  // Norm-stage result
  logic        carry, ovf;
  logic [22:0] man_n;
  logic [8:0]  exp_n;
  logic [31:0] pre_word, norm_word;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state: one step per clock once a capture leaves IDLE
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (r_i) state_d = StAlign;
      end
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StPack;
      StPack:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Exponent compare and mantissa alignment; a zero operand bypasses the adder
  always_comb begin
    ea         = acc_q[30:23];
    eb         = op_q[30:23];
    a_zero     = (ea == 8'd0);
    b_zero     = (eb == 8'd0);
    a_big      = (ea >= eb);
    big_e      = a_big ? ea : eb;
    diff       = a_big ? (ea - eb) : (eb - ea);
    big_m      = a_big ? {1'b1, acc_q[22:0]} : {1'b1, op_q[22:0]};
    small_m    = a_big ? {1'b1, op_q[22:0]} : {1'b1, acc_q[22:0]};
    small_sh   = (diff >= 8'd25) ? 24'd0 : (small_m >> diff[4:0]);
    bypass_val = b_zero ? acc_q : {1'b0, op_q};
  end

  // Normalise the 25-bit sum and saturate when the exponent hits 255
  always_comb begin
    carry     = sum_q[24];
    man_n     = carry ? sum_q[23:1] : sum_q[22:0];
    exp_n     = {1'b0, exp_q} + {8'd0, carry};
    pre_word  = bypass_q ? bypass_val_q : {1'b0, exp_n[7:0], man_n};
    ovf       = bypass_q ? (bypass_val_q[30:23] == 8'hFF) : (exp_n >= 9'd255);
    norm_word = ovf ? PosInf : pre_word;
  end

  // Datapath registers, advanced by the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      op_q         <= '0;
      eflag_q      <= 1'b0;
      exp_q        <= '0;
      man_a_q      <= '0;
      man_b_q      <= '0;
      sum_q        <= '0;
      bypass_q     <= 1'b0;
      bypass_val_q <= '0;
      sum_word_q   <= '0;
      ovf_q        <= 1'b0;
      res_q        <= '0;
      err_q        <= 1'b0;
      r_o_q        <= 1'b0;
    end else begin
      r_o_q <= (state_q == StPack);
      unique case (state_q)
        StIdle: begin
          // Clear takes effect before a same-edge capture accumulates
          if (clr) begin
            acc_q <= '0;
            err_q <= 1'b0;
          end
          if (r_i) begin
            op_q    <= x[30:0];
            eflag_q <= err_i;
          end
        end
        StAlign: begin
          exp_q        <= big_e;
          man_a_q      <= big_m;
          man_b_q      <= small_sh;
          bypass_q     <= a_zero | b_zero;
          bypass_val_q <= bypass_val;
        end
        StAdd: sum_q <= {1'b0, man_a_q} + {1'b0, man_b_q};
        StNorm: begin
          sum_word_q <= norm_word;
          ovf_q      <= ovf;
        end
        StPack: begin
          acc_q <= sum_word_q;
          res_q <= sum_word_q;
          err_q <= err_q | eflag_q | ovf_q;
        end
        default: ;
      endcase
    end
  end

  assign res = res_q;
  assign err = err_q;
  assign r_o = r_o_q;

endmodule

// File: tb/tb_sumsq_acc_fsm.sv
// Self-checking bench for sumsq_acc_fsm: expected {res, err} pairs are queued
// when a capture is driven and compared when the result pulse appears.
module tb_sumsq_acc_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] x = '0;
  logic        err_i = 1'b0;
  logic        r_i = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] res;
  logic        err;
  logic        r_o;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb_q[$];

  sumsq_acc_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .err_i (err_i),
    .r_i   (r_i),
    .clr   (clr),
    .res   (res),
    .err   (err),
    .r_o   (r_o),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One capture; optionally toggles r_i/clr/x while busy to show they are ignored
  task automatic xact(input string tag, input logic [31:0] xv, input logic ei,
                      input logic cl, input logic [31:0] exp_res, input logic exp_err,
                      input logic noise);
    logic [32:0] e;
    int          lat;
    bit          got;
    @(negedge clk);
    x = xv; err_i = ei; clr = cl; r_i = 1'b1;
    sb_q.push_back({exp_res, exp_err});
    @(posedge clk); #1;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    r_i = noise; clr = noise; err_i = noise;
    if (noise) x = 32'hDEAD_BEEF;
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (r_o) got = 1'b1;
    end
    r_i = 1'b0; clr = 1'b0; err_i = 1'b0;
    check_eq({tag, "_lat"}, lat, 4);
    e = sb_q.pop_front();
    if (got) begin
      check_eq({tag, "_res"}, res, e[32:1]);
      check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e[0]});
      check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    check_eq({tag, "_rofall"}, {31'd0, r_o}, 32'd0);
  endtask

  initial begin
    #12;
    check_eq("rst_res", res, 32'h0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_ro", {31'd0, r_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    xact("one_a", 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    xact("one_b", 32'h3F80_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b1);

    // Clear alone: res holds until the next PACK
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check_eq("clr_hold", res, 32'h4000_0000);
    xact("five_a", 32'h4080_0000, 1'b0, 1'b0, 32'h4080_0000, 1'b0, 1'b0);
    xact("five_b", 32'h3F80_0000, 1'b0, 1'b0, 32'h40A0_0000, 1'b0, 1'b0);

    xact("far_a", 32'h4E80_0000, 1'b0, 1'b1, 32'h4E80_0000, 1'b0, 1'b0);
    xact("far_b", 32'h3F80_0000, 1'b0, 1'b0, 32'h4E80_0000, 1'b0, 1'b0);

    xact("ovf_a", 32'h7F00_0000, 1'b0, 1'b1, 32'h7F00_0000, 1'b0, 1'b0);
    xact("ovf_b", 32'h7F00_0000, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    xact("ovf_c", 32'h3F80_0000, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);

    xact("clrcap", 32'h4110_0000, 1'b0, 1'b1, 32'h4110_0000, 1'b0, 1'b0);
    xact("erri", 32'h3F80_0000, 1'b1, 1'b0, 32'h4120_0000, 1'b1, 1'b0);
    xact("zero_op", 32'h0000_0000, 1'b0, 1'b0, 32'h4120_0000, 1'b1, 1'b0);
    xact("zero_clr", 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    xact("three", 32'h4040_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    xact("carry", 32'h3FC0_0000, 1'b0, 1'b0, 32'h4090_0000, 1'b0, 1'b0);

    // Reset during ADD aborts the addition
    @(negedge clk); x = 32'h3F80_0000; r_i = 1'b1;
    @(posedge clk); #1; r_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_eq("abort_res", res, 32'h0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_err", {31'd0, err}, 32'd0);
    check_eq("abort_ro", {31'd0, r_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (r_o) pulses++;
      end
      check_eq("abort_nopulse", pulses, 0);
    end
    xact("after_rst", 32'h4040_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
